// File: rtl/lsu_mem_stage_if.sv
// Bus bundle for lsu_mem_stage: core request, data-memory access and response channels.
// slave is the LSU's view; master is the core/memory environment's view.
interface lsu_mem_stage_if #(
  parameter int DM_ADDRESS = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_read;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [2:0]            req_funct3;
  logic [4:0]            req_rd;
  logic                  mem_read;
  logic                  mem_write;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [4:0]            resp_rd;
  logic                  resp_err;

  modport slave (
    input  req_valid, req_read, req_write, req_addr, req_wdata, req_funct3, req_rd,
    output req_ready,
    output mem_read, mem_write, mem_addr, mem_be, mem_wdata,
    input  mem_rdata,
    output resp_valid, resp_data, resp_rd, resp_err,
    input  resp_ready
  );

  modport master (
    output req_valid, req_read, req_write, req_addr, req_wdata, req_funct3, req_rd,
    input  req_ready,
    input  mem_read, mem_write, mem_addr, mem_be, mem_wdata,
    output mem_rdata,
    input  resp_valid, resp_data, resp_rd, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit feeding a word-addressed data memory: one request in flight, one response each.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating offsets.
module lsu_mem_stage #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1
) (
  input logic            clk,
  input logic            reset_n,
  lsu_mem_stage_if.slave bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        cap_f3;
  logic [1:0]        cap_off;
  logic              cap_load;

  logic [1:0]        off;
  logic [1:0]        eff_off;
  logic              legal;
  logic              misalign;
  logic              req_err;
  logic [3:0]        be;
  logic [DATA_W-1:0] lane;
  logic [15:0]       sh16;
  logic [DATA_W-1:0] load_val;

  always_comb begin
    off      = bus.req_addr[1:0];
    eff_off  = off;
    misalign = 1'b0;
    be       = '0;
    lane     = bus.req_wdata;
    if (bus.req_read)
      legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    case (bus.req_funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << off;
        lane = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = off[0];
`else
        eff_off  = off & 2'b10;
`endif
        be   = 4'b0011 << eff_off;
        lane = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = |off;
`else
        eff_off  = 2'b00;
`endif
        be   = 4'b1111;
        lane = bus.req_wdata;
      end
      default: ;
    endcase
    req_err = (bus.req_read & bus.req_write) |
              ((bus.req_read | bus.req_write) & (~legal | misalign));
  end

  // Only the low halfword of the lane-shifted word is ever needed for sub-word loads.
  always_comb begin
    sh16 = 16'(bus.mem_rdata >> {cap_off, 3'b000});
    case (cap_f3)
      3'b000:  load_val = {{24{sh16[7]}}, sh16[7:0]};
      3'b001:  load_val = {{16{sh16[15]}}, sh16};
      3'b100:  load_val = {24'b0, sh16[7:0]};
      3'b101:  load_val = {16'b0, sh16};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_f3         <= '0;
      cap_off        <= '0;
      cap_load       <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_be     <= '0;
      bus.mem_wdata  <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_rd    <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            bus.resp_rd   <= bus.req_rd;
            cap_f3        <= bus.req_funct3;
            cap_off       <= eff_off;
            cap_load      <= bus.req_read;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_data  <= bus.req_addr;
            end else if (!bus.req_read && !bus.req_write) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b0;
              bus.resp_data  <= '0;
            end else begin
              state         <= ACCESS;
              cnt           <= '0;
              bus.mem_read  <= bus.req_read;
              bus.mem_write <= bus.req_write;
              bus.mem_addr  <= {bus.req_addr[DM_ADDRESS-1:2], 2'b00};
              bus.mem_be    <= bus.req_write ? be : 4'b0000;
              bus.mem_wdata <= lane;
            end
          end
        end
        ACCESS: begin
          bus.mem_write <= 1'b0;
          bus.mem_be    <= '0;
          cnt           <= cnt + 1'b1;
          if (cnt == LAST) begin
            state          <= RESP;
            bus.mem_read   <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_data  <= cap_load ? load_val : '0;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
